// File: rtl/shot_responder.sv
// shot_responder: own-board responder for a battleship-style game.
// Own ship cells are placed one by one, the board is locked, and every
// accepted opponent shot is answered two cycles later with a hit/miss pulse.
// Optional feature macro: SHOT_RESPONDER_REPEAT_HIT_EN -- when defined, a
// repeated shot on an already-hit ship cell answers hit=1 (default: hit=0).
module shot_responder #(
    parameter int BOARD_N    = 10,
    parameter int SHIP_CELLS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ship_wr,
    input  logic [7:0] ship_pos,
    input  logic       board_lock,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    output logic       shot_ready,
    output logic       answer,
    output logic       hit,
    output logic [4:0] cells_left,
    output logic       defeat
);

    localparam int         IW     = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
    localparam logic [4:0] N_LIM  = 5'(BOARD_N);
    localparam logic [4:0] SHIPS  = 5'(SHIP_CELLS);

`ifdef SHOT_RESPONDER_REPEAT_HIT_EN
    localparam logic REPEAT_HIT = 1'b1;
`else
    localparam logic REPEAT_HIT = 1'b0;
`endif

    typedef enum logic [2:0] {PLACE, ARMED, CHECK, RESP, DONE} state_t;

    state_t                            state_q;
    logic [BOARD_N-1:0][BOARD_N-1:0]   ship_map_q;
    logic [BOARD_N-1:0][BOARD_N-1:0]   hit_map_q;
    logic [4:0]                        placed_q;
    logic [4:0]                        cells_left_q;
    logic [7:0]                        shot_q;
    logic                              answer_q;
    logic                              hit_q;

    logic [IW-1:0] wr_row, wr_col, sh_row, sh_col;
    logic          wr_in_range, wr_ok, sh_in_range;

    // Decode placement request and captured shot coordinates
    always_comb begin
        wr_row      = ship_pos[4 +: IW];
        wr_col      = ship_pos[0 +: IW];
        sh_row      = shot_q[4 +: IW];
        sh_col      = shot_q[0 +: IW];
        wr_in_range = ({1'b0, ship_pos[7:4]} < N_LIM) && ({1'b0, ship_pos[3:0]} < N_LIM);
        sh_in_range = ({1'b0, shot_q[7:4]} < N_LIM) && ({1'b0, shot_q[3:0]} < N_LIM);
        // Only in-range, empty cells count, and never beyond the fleet size
        wr_ok       = ship_wr && wr_in_range && !ship_map_q[wr_row][wr_col]
                      && (placed_q < SHIPS);
    end

    // Game FSM: placement, shot capture, map lookup, answer pulse, defeat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PLACE;
            ship_map_q   <= '0;
            hit_map_q    <= '0;
            placed_q     <= '0;
            cells_left_q <= '0;
            shot_q       <= '0;
            answer_q     <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            // answer/hit are single-cycle pulses owned by RESP
            answer_q <= 1'b0;
            hit_q    <= 1'b0;
            case (state_q)
                PLACE: begin
                    // A successful lock wins over a same-cycle write
                    if (board_lock && (placed_q == SHIPS)) begin
                        state_q      <= ARMED;
                        cells_left_q <= SHIPS;
                    end else if (wr_ok) begin
                        ship_map_q[wr_row][wr_col] <= 1'b1;
                        placed_q                   <= placed_q + 5'd1;
                    end
                end
                ARMED: begin
                    if (shot_valid) begin
                        shot_q  <= shot_pos;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q  <= RESP;
                    answer_q <= 1'b1;
                    if (sh_in_range && ship_map_q[sh_row][sh_col]) begin
                        if (!hit_map_q[sh_row][sh_col]) begin
                            hit_map_q[sh_row][sh_col] <= 1'b1;
                            hit_q                     <= 1'b1;
                            if (cells_left_q != 5'd0) begin
                                cells_left_q <= cells_left_q - 5'd1;
                            end
                        end else begin
                            hit_q <= REPEAT_HIT;
                        end
                    end
                end
                RESP: begin
                    state_q <= (cells_left_q == 5'd0) ? DONE : ARMED;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= PLACE;
                end
            endcase
        end
    end

    assign shot_ready = (state_q == ARMED);
    assign defeat     = (state_q == DONE);
    assign answer     = answer_q;
    assign hit        = hit_q;
    assign cells_left = cells_left_q;

endmodule
